// File: rtl/div_share_ctrl.sv
// Two-requester front end around a single combinational divider.
// Round-robin grant, one operation in flight, registered quotient and dbz status.

module div #(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quot,
   output logic             dbz
);

   logic [WIDTH:0] rem;

   // Restoring long division; a zero divisor yields all-ones, masked by the caller anyway.
   always_comb begin
      rem  = '0;
      quot = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         rem = {rem[WIDTH-1:0], dividend[i]};
         if (rem >= {1'b0, divisor}) begin
            rem     = rem - {1'b0, divisor};
            quot[i] = 1'b1;
         end
      end
   end

   assign dbz = (divisor == '0);

endmodule

// state | meaning
// IDLE  | arbitrate, accept one request
// CALC  | operands registered, capture divider result
// RESP  | result presented to the source until it takes it
module div_share_ctrl #(
   parameter int WIDTH = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_dividend,
   input  logic [WIDTH-1:0] req0_divisor,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_dividend,
   input  logic [WIDTH-1:0] req1_divisor,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_quot,
   output logic             rsp_dbz,
   output logic             busy,
   output logic [CNT_W-1:0] dbz_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             rr_ptr;
   logic             src;
   logic [WIDTH-1:0] op_dividend;
   logic [WIDTH-1:0] op_divisor;
   logic             grant0;
   logic             grant1;
   logic             acc0;
   logic             acc1;
   logic             rsp_hs;
   logic [WIDTH-1:0] div_quot;
   logic             div_dbz;

   div #(
      .WIDTH (WIDTH)
   ) u_div (
      .dividend (op_dividend),
      .divisor  (op_divisor),
      .quot     (div_quot),
      .dbz      (div_dbz)
   );

   // rr_ptr names the requester that wins a tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rr_ptr) begin
         grant0 = req0_valid;
         grant1 = req1_valid & ~req0_valid;
      end else begin
         grant1 = req1_valid;
         grant0 = req0_valid & ~req1_valid;
      end
   end

   assign req0_ready = ~rst & (state == IDLE) & grant0;
   assign req1_ready = ~rst & (state == IDLE) & grant1;
   assign acc0       = req0_valid & req0_ready;
   assign acc1       = req1_valid & req1_ready;
   assign rsp_hs     = (state == RESP) & rsp_ready[src];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc0 || acc1) state_nxt = CALC;
         CALC:    state_nxt = RESP;
         RESP:    if (rsp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rsp_valid = 2'b00;
      busy      = (state != IDLE);
      if (state == RESP) begin
         rsp_valid[src] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= 1'b0;
         src         <= 1'b0;
         op_dividend <= '0;
         op_divisor  <= '0;
         rsp_quot    <= '0;
         rsp_dbz     <= 1'b0;
         dbz_cnt     <= '0;
      end else begin
         if (acc0) begin
            op_dividend <= req0_dividend;
            op_divisor  <= req0_divisor;
            src         <= 1'b0;
         end else if (acc1) begin
            op_dividend <= req1_dividend;
            op_divisor  <= req1_divisor;
            src         <= 1'b1;
         end
         if (state == CALC) begin
            rsp_quot <= div_dbz ? {WIDTH{1'b1}} : div_quot;
            rsp_dbz  <= div_dbz;
            if (div_dbz && (dbz_cnt != {CNT_W{1'b1}})) begin
               dbz_cnt <= dbz_cnt + CNT_W'(1);
            end
         end
         if (rsp_hs) begin
            rr_ptr <= ~src;
         end
      end
   end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: scoreboard of expected responses filled at accept time,
// drained by a monitor whenever a response handshake is observed.

module tb_div_share_ctrl;

   typedef struct {
      logic       src;
      logic [5:0] quot;
      logic       dbz;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       req0_valid;
   logic       req0_ready;
   logic [5:0] req0_dividend;
   logic [5:0] req0_divisor;
   logic       req1_valid;
   logic       req1_ready;
   logic [5:0] req1_dividend;
   logic [5:0] req1_divisor;
   logic [1:0] rsp_valid;
   logic [1:0] rsp_ready;
   logic [5:0] rsp_quot;
   logic       rsp_dbz;
   logic       busy;
   logic [7:0] dbz_cnt;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   logic rr_m  = 1'b0;
   int   cnt_m = 0;

   div_share_ctrl #(.WIDTH(6), .CNT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req0_dividend (req0_dividend),
      .req0_divisor  (req0_divisor),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .req1_dividend (req1_dividend),
      .req1_divisor  (req1_divisor),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_quot      (rsp_quot),
      .rsp_dbz       (rsp_dbz),
      .busy          (busy),
      .dbz_cnt       (dbz_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Response monitor: pops the scoreboard on each observed handshake.
   always @(negedge clk) begin
      if (!rst && ((rsp_valid & rsp_ready) != 2'b00)) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: rsp_valid=%b quot=%0d dbz=%b, required no response", rsp_valid, rsp_quot, rsp_dbz);
         end else begin
            mon_e = sb.pop_front();
            if (rsp_valid !== (mon_e.src ? 2'b10 : 2'b01) || rsp_quot !== mon_e.quot || rsp_dbz !== mon_e.dbz) begin
               bad++;
               $display("FAIL rsp_data: valid=%b quot=%0d dbz=%b, required valid=%b quot=%0d dbz=%b",
                        rsp_valid, rsp_quot, rsp_dbz, (mon_e.src ? 2'b10 : 2'b01), mon_e.quot, mon_e.dbz);
            end
            rr_m = ~mon_e.src;
         end
      end
   end

   task automatic push_exp(input logic s, input logic [5:0] dd, input logic [5:0] dv);
      exp_t e;
      e.src  = s;
      e.dbz  = (dv == 6'd0);
      e.quot = (dv == 6'd0) ? 6'h3F : 6'(dd / dv);
      sb.push_back(e);
      if (dv == 6'd0 && cnt_m < 255) cnt_m++;
   endtask

   task automatic set_req(input int r, input logic v, input logic [5:0] dd, input logic [5:0] dv);
      if (r == 0) begin
         req0_valid = v; req0_dividend = dd; req0_divisor = dv;
      end else begin
         req1_valid = v; req1_dividend = dd; req1_divisor = dv;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      rr_m  = 1'b0;
      cnt_m = 0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) done = 1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL %s_idle_timeout: busy=%b pending=%0d, required busy=0 pending=0", name, busy, sb.size());
      end
   endtask

   task automatic issue(input int r, input logic [5:0] dd, input logic [5:0] dv);
      bit got = 0;
      @(posedge clk); #1;
      set_req(r, 1'b1, dd, dv);
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if ((r == 0) ? req0_ready : req1_ready) begin
            got = 1;
            push_exp(r[0], dd, dv);
         end
         @(posedge clk); #1;
      end
      set_req(r, 1'b0, dd, dv);
      if (!got) begin
         total++; bad++;
         $display("FAIL issue_timeout: req%0d ready=0, required accept", r);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rsp_ready = 2'b11;
      set_req(0, 1'b1, 6'd10, 6'd2);
      set_req(1, 1'b1, 6'd11, 6'd3);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_quot !== 6'd0 || rsp_dbz !== 1'b0 || dbz_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_state: valid=%b busy=%b quot=%0d dbz=%b cnt=%0d, required all 0",
                  rsp_valid, busy, rsp_quot, rsp_dbz, dbz_cnt);
      end
      set_req(0, 1'b0, 6'd0, 6'd0);
      set_req(1, 1'b0, 6'd0, 6'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_latency();
      @(posedge clk); #1;
      set_req(0, 1'b1, 6'd45, 6'd7);
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b1) begin
         bad++;
         $display("FAIL lat_accept: ready0=%b, required 1", req0_ready);
      end else begin
         push_exp(1'b0, 6'd45, 6'd7);
      end
      @(posedge clk); #1;
      set_req(0, 1'b0, 6'd0, 6'd0);
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
         bad++;
         $display("FAIL lat_calc: valid=%b busy=%b, required 00 1", rsp_valid, busy);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b01 || rsp_quot !== 6'd6 || rsp_dbz !== 1'b0) begin
         bad++;
         $display("FAIL lat_resp: valid=%b quot=%0d dbz=%b, required 01 6 0", rsp_valid, rsp_quot, rsp_dbz);
      end
      wait_idle("latency");
   endtask

   task automatic test_arbitration(input string name, input logic [5:0] a_dd, input logic [5:0] a_dv,
                                   input logic [5:0] b_dd, input logic [5:0] b_dv);
      int   first;
      bit   p0;
      bit   p1;
      logic exp_first;
      first     = -1;
      p0        = 1;
      p1        = 1;
      exp_first = rr_m;
      @(posedge clk); #1;
      set_req(0, 1'b1, a_dd, a_dv);
      set_req(1, 1'b1, b_dd, b_dv);
      for (int n = 0; n < 60 && (p0 || p1); n++) begin
         @(negedge clk);
         if (req0_ready && p0) begin
            push_exp(1'b0, a_dd, a_dv); p0 = 0;
            if (first < 0) first = 0;
         end
         if (req1_ready && p1) begin
            push_exp(1'b1, b_dd, b_dv); p1 = 0;
            if (first < 0) first = 1;
         end
         @(posedge clk); #1;
         if (!p0) req0_valid = 1'b0;
         if (!p1) req1_valid = 1'b0;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      total++;
      if (p0 || p1) begin
         bad++;
         $display("FAIL %s_timeout: pending0=%0d pending1=%0d, required both accepted", name, p0, p1);
      end
      total++;
      if (first != (exp_first ? 1 : 0)) begin
         bad++;
         $display("FAIL %s_first: granted req%0d first, required req%0d", name, first, exp_first);
      end
      wait_idle(name);
   endtask

   task automatic test_dbz();
      issue(1, 6'd13, 6'd0);
      wait_idle("dbz1");
      total++;
      if (dbz_cnt !== 8'(cnt_m)) begin
         bad++;
         $display("FAIL dbz_cnt_first: cnt=%0d, required %0d", dbz_cnt, cnt_m);
      end
      for (int i = 0; i < 299; i++) issue(i % 2, 6'(i), 6'd0);
      wait_idle("dbz300");
      total++;
      if (dbz_cnt !== 8'd255) begin
         bad++;
         $display("FAIL dbz_cnt_sat: cnt=%0d, required 255", dbz_cnt);
      end
   endtask

   task automatic test_backpressure();
      rsp_ready = 2'b00;
      issue(0, 6'd9, 6'd9);
      set_req(0, 1'b1, 6'd30, 6'd3);
      set_req(1, 1'b1, 6'd31, 6'd4);
      @(negedge clk);
      @(posedge clk); #1;
      rsp_ready = 2'b10;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 2'b01 || rsp_quot !== 6'd1 || rsp_dbz !== 1'b0 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_%0d: valid=%b quot=%0d ready0=%b ready1=%b busy=%b, required 01 1 0 0 1",
                     n, rsp_valid, rsp_quot, req0_ready, req1_ready, busy);
         end
         @(posedge clk); #1;
      end
      set_req(0, 1'b0, 6'd0, 6'd0);
      set_req(1, 1'b0, 6'd0, 6'd0);
      rsp_ready = 2'b11;
      wait_idle("hold");
   endtask

   task automatic test_rst_in_calc();
      bit seen = 0;
      @(posedge clk); #1;
      set_req(0, 1'b1, 6'd5, 6'd9);
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b1) begin
         bad++;
         $display("FAIL rstcalc_accept: ready0=%b, required 1", req0_ready);
      end
      @(posedge clk); #1;
      set_req(0, 1'b0, 6'd0, 6'd0);
      rst = 1'b1;
      set_req(1, 1'b1, 6'd7, 6'd1);
      @(negedge clk);
      total++;
      if (req1_ready !== 1'b0) begin
         bad++;
         $display("FAIL rstcalc_ready: ready1=%b, required 0 during reset", req1_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(1, 1'b0, 6'd0, 6'd0);
      rr_m  = 1'b0;
      cnt_m = 0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || dbz_cnt !== 8'd0) begin
         bad++;
         $display("FAIL rstcalc_state: valid=%b busy=%b cnt=%0d, required 00 0 0", rsp_valid, busy, dbz_cnt);
      end
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (rsp_valid !== 2'b00) seen = 1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL rstcalc_dropped: a response appeared, required none");
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] dd_tab [8] = '{6'd63, 6'd0, 6'd63, 6'd5, 6'd62, 6'd40, 6'd1, 6'd17};
      logic [5:0] dv_tab [8] = '{6'd1, 6'd5, 6'd63, 6'd9, 6'd0, 6'd3, 6'd2, 6'd17};
      for (int i = 0; i < 8; i++) issue(i % 2, dd_tab[i], dv_tab[i]);
      for (int i = 0; i < 24; i++) begin
         issue(int'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
               (i % 5 == 0) ? 6'd0 : 6'($urandom_range(1, 63)));
      end
      wait_idle("b2b");
      total++;
      if (dbz_cnt !== 8'(cnt_m)) begin
         bad++;
         $display("FAIL b2b_cnt: cnt=%0d, required %0d", dbz_cnt, cnt_m);
      end
   endtask

   initial begin
      rst = 1'b1;
      rsp_ready = 2'b11;
      req0_valid = 1'b0; req0_dividend = '0; req0_divisor = '0;
      req1_valid = 1'b0; req1_dividend = '0; req1_divisor = '0;
      test_reset();
      test_latency();
      do_reset();
      test_arbitration("arb_t2", 6'd20, 6'd4, 6'd63, 6'd1);
      issue(0, 6'd12, 6'd5);
      wait_idle("pre_t3");
      test_arbitration("arb_t3", 6'd33, 6'd11, 6'd50, 6'd7);
      test_dbz();
      test_backpressure();
      test_rst_in_calc();
      test_back_to_back();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: pending=%0d, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
